// File: rtl/diag_sequencer.sv
// Diagnostic pass sequencer: streams test-result rows through the loop chain,
// writes one fault-map entry per row, then recirculates the chain to build summaries.
module diag_sequencer #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     row_rd_en,
  output logic [ADDR_WIDTH-1:0]    row_rd_addr,
  input  logic [SYSTOLIC_SIZE-1:0] row_rd_data,
  output logic                     chain_clr,
  output logic                     chain_en,
  output logic [SYSTOLIC_SIZE-1:0] chain_col_inputs,
  input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
  input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
  input  logic [SYSTOLIC_SIZE-1:0] row_fault_detection,
  output logic                     fm_wr_valid,
  input  logic                     fm_wr_ready,
  output logic [ADDR_WIDTH-1:0]    fm_wr_addr,
  output logic [SYSTOLIC_SIZE-1:0] fm_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [SYSTOLIC_SIZE-1:0] col_fault_summary,
  output logic [SYSTOLIC_SIZE-1:0] row_fault_summary
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(0);
  localparam logic [SYSTOLIC_SIZE-1:0] VEC_ZERO = {SYSTOLIC_SIZE{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                   state_r, state_s;
  logic [ADDR_WIDTH-1:0]    row_r, row_s;
  logic [ADDR_WIDTH-1:0]    chk_r, chk_s;
  logic [SYSTOLIC_SIZE-1:0] wr_data_r, wr_data_s;
  logic [SYSTOLIC_SIZE-1:0] col_sum_r, col_sum_s;
  logic [SYSTOLIC_SIZE-1:0] row_sum_r, row_sum_s;
  logic rd_en_r, rd_en_s;
  logic clr_r, clr_s;
  logic chain_en_r, chain_en_s;
  logic shift_sel_r, shift_sel_s;
  logic wr_valid_r, wr_valid_s;
  logic done_r, done_s;
  logic busy_r, busy_s;

  // Control outputs are registered: each is computed for the state being entered.
  always_comb begin
    state_s     = state_r;
    row_s       = row_r;
    chk_s       = chk_r;
    wr_data_s   = wr_data_r;
    col_sum_s   = col_sum_r;
    row_sum_s   = row_sum_r;
    rd_en_s     = 1'b0;
    clr_s       = 1'b0;
    chain_en_s  = 1'b0;
    shift_sel_s = 1'b0;
    wr_valid_s  = 1'b0;
    done_s      = 1'b0;

    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      chk_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s   = ST_FETCH;
            row_s     = IDX_ZERO;
            col_sum_s = VEC_ZERO;
            row_sum_s = VEC_ZERO;
            clr_s     = 1'b1;
            rd_en_s   = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          state_s     = ST_SHIFT;
          chain_en_s  = 1'b1;
          shift_sel_s = 1'b1;
        end
        ST_SHIFT: begin
          wr_data_s  = single_pe_detection;
          state_s    = ST_WRITE;
          wr_valid_s = 1'b1;
        end
        ST_WRITE: begin
          // The chain stays frozen (chain_en low) for as long as the write stalls.
          if (fm_wr_ready) begin
            if (row_r == LAST_IDX) begin
              state_s    = ST_CHECK;
              chk_s      = IDX_ZERO;
              chain_en_s = 1'b1;
            end else begin
              row_s   = row_r + IDX_ONE;
              state_s = ST_FETCH;
              rd_en_s = 1'b1;
            end
          end else begin
            wr_valid_s = 1'b1;
          end
        end
        ST_CHECK: begin
          col_sum_s = col_sum_r | column_fault_detection;
          row_sum_s = row_sum_r | row_fault_detection;
          if (chk_r == LAST_IDX) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            chk_s      = chk_r + IDX_ONE;
            chain_en_s = 1'b1;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and output registers; reset clears everything visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      row_r       <= IDX_ZERO;
      chk_r       <= IDX_ZERO;
      wr_data_r   <= VEC_ZERO;
      col_sum_r   <= VEC_ZERO;
      row_sum_r   <= VEC_ZERO;
      rd_en_r     <= 1'b0;
      clr_r       <= 1'b0;
      chain_en_r  <= 1'b0;
      shift_sel_r <= 1'b0;
      wr_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      row_r       <= row_s;
      chk_r       <= chk_s;
      wr_data_r   <= wr_data_s;
      col_sum_r   <= col_sum_s;
      row_sum_r   <= row_sum_s;
      rd_en_r     <= rd_en_s;
      clr_r       <= clr_s;
      chain_en_r  <= chain_en_s;
      shift_sel_r <= shift_sel_s;
      wr_valid_r  <= wr_valid_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

  // Buffer data only arrives during SHIFT, so the column inputs are gated rather than registered.
  assign chain_col_inputs  = shift_sel_r ? row_rd_data : VEC_ZERO;
  assign row_rd_en         = rd_en_r;
  assign row_rd_addr       = row_r;
  assign chain_clr         = clr_r;
  assign chain_en          = chain_en_r;
  assign fm_wr_valid       = wr_valid_r;
  assign fm_wr_addr        = row_r;
  assign fm_wr_data        = wr_data_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign col_fault_summary = col_sum_r;
  assign row_fault_summary = row_sum_r;

endmodule

// File: tb/tb_diag_sequencer.sv
// Bench for diag_sequencer: behavioural buffer and chain models, an expected
// per-cycle phase schedule built from the pass rules, and directed plus random passes.
module tb_diag_sequencer;

  localparam int N  = 8;
  localparam int AW = $clog2(N);
  localparam int K_FETCH = 1, K_SHIFT = 2, K_WRITE = 3, K_CHECK = 4, K_DONE = 5;

  typedef struct {
    int kind;
    int row;
    bit ready;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          row_rd_en;
  logic [AW-1:0] row_rd_addr;
  logic [N-1:0]  row_rd_data;
  logic          chain_clr, chain_en;
  logic [N-1:0]  chain_col_inputs;
  logic [N-1:0]  single_pe_detection, column_fault_detection, row_fault_detection;
  logic          fm_wr_valid, fm_wr_ready;
  logic [AW-1:0] fm_wr_addr;
  logic [N-1:0]  fm_wr_data;
  logic          busy, done;
  logic [N-1:0]  col_fault_summary, row_fault_summary;

  logic [N-1:0] mem [N];
  logic [N-1:0] acc = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  diag_sequencer #(.SYSTOLIC_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .row_rd_en(row_rd_en), .row_rd_addr(row_rd_addr), .row_rd_data(row_rd_data),
    .chain_clr(chain_clr), .chain_en(chain_en), .chain_col_inputs(chain_col_inputs),
    .single_pe_detection(single_pe_detection),
    .column_fault_detection(column_fault_detection),
    .row_fault_detection(row_fault_detection),
    .fm_wr_valid(fm_wr_valid), .fm_wr_ready(fm_wr_ready),
    .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data),
    .busy(busy), .done(done),
    .col_fault_summary(col_fault_summary), .row_fault_summary(row_fault_summary)
  );

  // Test-result buffer: one-cycle read latency, garbage when not read.
  always @(posedge clk) row_rd_data <= row_rd_en ? mem[row_rd_addr] : N'($urandom);

  // Loop chain: detected faults persist and feed back into later rows.
  always @(posedge clk) begin
    if (chain_clr) acc <= '0;
    else if (chain_en) acc <= acc | chain_col_inputs;
  end
  assign single_pe_detection = acc | chain_col_inputs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input bit full);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_chain_en"}, chain_en, 0);
    chk({tag, "_chain_clr"}, chain_clr, 0);
    chk({tag, "_col_in"}, chain_col_inputs, 0);
    chk({tag, "_wr_valid"}, fm_wr_valid, 0);
    chk({tag, "_rd_en"}, row_rd_en, 0);
    if (full) begin
      chk({tag, "_col_sum"}, col_fault_summary, 0);
      chk({tag, "_row_sum"}, row_fault_summary, 0);
      chk({tag, "_wr_data"}, fm_wr_data, 0);
      chk({tag, "_wr_addr"}, fm_wr_addr, 0);
      chk({tag, "_rd_addr"}, row_rd_addr, 0);
    end
  endtask

  // intr_kind: 0 none, 1 abort, 2 rst, applied during schedule cycle intr_at.
  task automatic run_pass(input int stall_row, input int stall_len,
                          input int intr_kind, input int intr_at);
    rec_t q[$];
    rec_t rec;
    logic [N-1:0] cum [N];
    logic [N-1:0] exp_col, exp_row;
    int writes, exp_writes, done_at;
    bit cut;

    for (int r = 0; r < N; r++) begin
      q.push_back('{K_FETCH, r, 1'b0});
      q.push_back('{K_SHIFT, r, 1'b0});
      if (r == stall_row)
        for (int s = 0; s < stall_len; s++) q.push_back('{K_WRITE, r, 1'b0});
      q.push_back('{K_WRITE, r, 1'b1});
    end
    for (int c = 0; c < N; c++) q.push_back('{K_CHECK, 0, 1'b0});
    q.push_back('{K_DONE, 0, 1'b0});

    cum[0] = mem[0];
    for (int r = 1; r < N; r++) cum[r] = cum[r-1] | mem[r];
    exp_col = '0; exp_row = '0;
    writes = 0; exp_writes = 0; done_at = 0; cut = 1'b0;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= q.size(); k++) begin
      rec = q[k-1];
      fm_wr_ready = (rec.kind == K_WRITE) ? rec.ready : 1'($urandom);
      column_fault_detection = N'($urandom);
      row_fault_detection    = N'($urandom);
      start = (k % 5 == 2);
      abort = (intr_kind == 1 && k == intr_at);
      rst   = (intr_kind == 2 && k == intr_at);
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done", done, rec.kind == K_DONE);
      chk("chain_clr", chain_clr, k == 1);
      chk("rd_en", row_rd_en, rec.kind == K_FETCH);
      if (rec.kind == K_FETCH) chk("rd_addr", row_rd_addr, rec.row);
      chk("chain_en", chain_en, rec.kind == K_SHIFT || rec.kind == K_CHECK);
      chk("col_in", chain_col_inputs, (rec.kind == K_SHIFT) ? mem[rec.row] : N'(0));
      chk("wr_valid", fm_wr_valid, rec.kind == K_WRITE);
      if (rec.kind == K_WRITE) begin
        chk("wr_addr", fm_wr_addr, rec.row);
        chk("wr_data", fm_wr_data, cum[rec.row]);
      end
      if (rec.kind == K_CHECK) begin
        exp_col |= column_fault_detection;
        exp_row |= row_fault_detection;
      end
      if (rec.kind == K_DONE) begin
        chk("done_col_sum", col_fault_summary, exp_col);
        chk("done_row_sum", row_fault_summary, exp_row);
      end
      if (fm_wr_valid && fm_wr_ready && !abort && !rst) writes++;
      if (rec.kind == K_WRITE && rec.ready && !abort && !rst) exp_writes++;
      if (done) done_at = k;
      @(posedge clk); #1;
      if (abort || rst) begin
        cut = 1'b1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    @(negedge clk);
    if (cut) begin
      check_quiet(intr_kind == 2 ? "post_rst" : "post_abort", intr_kind == 2);
      chk("intr_writes", writes, exp_writes);
      repeat (3) @(negedge clk);
      chk("intr_no_done", done, 0);
      chk("intr_idle", busy, 0);
    end else begin
      check_quiet("post_done", 1'b0);
      chk("latency", done_at, 4*N + 1 + stall_len);
      chk("writes", writes, N);
      repeat (3) @(negedge clk);
      chk("hold_col_sum", col_fault_summary, exp_col);
      chk("hold_row_sum", row_fault_summary, exp_row);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fm_wr_ready = 1'b0;
    column_fault_detection = '0; row_fault_detection = '0;
    for (int r = 0; r < N; r++) mem[r] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 1'b1);
    #1 rst = 1'b0;

    // All-zero rows, ready always high.
    run_pass(-1, 0, 0, 0);

    // Single fault at row 3, column 2: feedback carries it into later rows.
    mem[3] = 8'h04;
    run_pass(-1, 0, 0, 0);

    // Five-cycle write stall at row 2.
    for (int r = 0; r < N; r++) mem[r] = N'($urandom) & N'($urandom);
    run_pass(2, 5, 0, 0);

    // Abort during the fourth CHECK cycle.
    run_pass(-1, 0, 1, 3*N + 4);

    // Abort together with ready in the WRITE of row 4.
    run_pass(-1, 0, 1, 15);

    // Reset in the middle of a stalled WRITE at row 2.
    run_pass(2, 4, 2, 10);

    // Fresh pass after reset, then random passes.
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < N; r++) mem[r] = N'($urandom) & N'($urandom);
      run_pass($urandom_range(0, N-1), $urandom_range(0, 3), 0, 0);
    end
    for (int r = 0; r < N; r++) mem[r] = N'($urandom);
    run_pass(-1, 0, 1, $urandom_range(1, 4*N));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/diag_sequencer.md
DIAG_SEQUENCER -- requirements
Module: diag_sequencer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, meaning array dimension N and the diagnostic chain length.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE), meaning the row index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1: begin a diagnosis pass; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of the current pass.
REQ-007 SHALL have ports row_rd_en (output, 1), row_rd_addr (output, ADDR_WIDTH) and row_rd_data (input, N): test-result buffer read; data is valid exactly 1 cycle after row_rd_en.
REQ-008 SHALL have ports chain_clr (output, 1), chain_en (output, 1) and chain_col_inputs (output, N), which drive the diagnostic loop chain.
REQ-009 SHALL have ports single_pe_detection, column_fault_detection and row_fault_detection, each input N, observed from the chain.
REQ-010 SHALL have ports fm_wr_valid (output, 1), fm_wr_ready (input, 1), fm_wr_addr (output, ADDR_WIDTH) and fm_wr_data (output, N): fault-map write handshake.
REQ-011 SHALL have ports busy (output, 1), done (output, 1), col_fault_summary (output, N) and row_fault_summary (output, N).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, SHIFT, WRITE, CHECK and DONE.
REQ-013 IDLE: on start=1, SHALL pulse chain_clr for 1 cycle, clear the row index r to 0, clear both summaries, then go to FETCH; start is ignored in all other states.
REQ-014 FETCH: SHALL assert row_rd_en=1 with row_rd_addr=r for exactly 1 cycle, then go to SHIFT.
REQ-015 SHIFT: SHALL assert chain_en=1 with chain_col_inputs=row_rd_data for exactly 1 cycle.
REQ-016 SHIFT: SHALL capture single_pe_detection into the write-data register in the same cycle, then go to WRITE.
REQ-017 WRITE: SHALL assert fm_wr_valid=1, with fm_wr_addr=r and fm_wr_data held stable, until fm_wr_ready=1 in the same cycle.
REQ-018 WRITE: chain_en SHALL be 0 throughout, so the chain holds its contents while the write stalls.
REQ-019 On the WRITE handshake: if r==N-1, SHALL go to CHECK with the check counter at 0; otherwise SHALL set r<=r+1 and go to FETCH.
REQ-020 CHECK: SHALL assert chain_en=1 with chain_col_inputs=0 for exactly N cycles, so the chain recirculates one full loop.
REQ-021 CHECK: each cycle, SHALL OR column_fault_detection into col_fault_summary and row_fault_detection into row_fault_summary; after the Nth cycle, SHALL go to DONE.
REQ-022 DONE: SHALL assert done=1 for exactly 1 cycle, then go to IDLE; the summaries hold until the next start or rst.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 chain_col_inputs SHALL be 0 whenever chain_en=0.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
REQ-026 After abort, chain_en, fm_wr_valid, row_rd_en and done SHALL be 0 from that edge, and no fault-map write SHALL complete.
REQ-027 If abort and fm_wr_ready are both 1 in WRITE, abort wins and the transfer is not counted.
REQ-028 Row index SHALL never exceed N-1, and the check counter SHALL count 0..N-1 with no wrap into a new pass.
REQ-029 With fm_wr_ready held 1, pass latency from the start edge to the done pulse SHALL be 3N+N+1 cycles (33 cycles for N=8).

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, r=0 and check counter=0.
REQ-031 rst=1 SHALL force all outputs to 0, including both summaries and fm_wr_data.
REQ-032 rst SHALL have priority over abort and start, and SHALL take effect mid-pass, including mid-WRITE stall.

Verification
REQ-033 N=8, all row_rd_data=0, fm_wr_ready=1, start pulse -> 8 writes with addr 0..7 and data 0, summaries 0, done exactly 33 cycles after start.
REQ-034 Row 3 data=8'h04, other rows 0 -> write for addr 3 carries bit 2 set, and every later write also carries bit 2 (loop feedback) -> col_fault_summary/row_fault_summary equal the union observed during CHECK.
REQ-035 fm_wr_ready held 0 for 5 cycles at row 2 -> fm_wr_valid, addr 2 and data stable for those 5 cycles, chain_en=0 during the stall, total latency 38.
REQ-036 abort asserted in CHECK cycle 4 -> IDLE next cycle, busy=0, no done pulse, chain_en=0.
REQ-037 start asserted again while busy -> ignored, no extra chain_clr; rst in WRITE -> all outputs 0 next cycle.
REQ-038 rst asserted in WRITE -> all outputs 0 on the next cycle and FSM in IDLE.
